// File: rtl/hilbert_pkg.sv
// Shared Hilbert constants, coefficient table, FSM state type and output saturation.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package hilbert_pkg;

    localparam int COEFF_WIDTH = 13;
    localparam int N           = 55;
    localparam int DELAY       = (N - 1) / 2;
    localparam int NK          = 14;   // distinct non-zero coefficient magnitudes
    localparam int ACC_WIDTH   = 34;   // wide enough that 14 terms can never overflow
    localparam int SAT_WIDTH   = 16;

    // Odd-symmetric taps: k[j] weights h[2j] and -k[j] weights h[54-2j]
    localparam logic signed [COEFF_WIDTH-1:0] HILBERT_K [NK] = '{
        13'sd8,   13'sd10,  13'sd15,  13'sd23,  13'sd36,  13'sd55,  13'sd80,
        13'sd114, 13'sd159, 13'sd223, 13'sd319, 13'sd482, 13'sd845, 13'sd2599
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Symmetric clamp so a later negation can never overflow
    function automatic logic signed [SAT_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0] pos_lim;
        logic signed [ACC_WIDTH-1:0] neg_lim;
        pos_lim = ACC_WIDTH'((2 ** (SAT_WIDTH - 1)) - 1);
        neg_lim = -pos_lim;
        if (v > pos_lim) begin
            saturate = pos_lim[SAT_WIDTH-1:0];
        end else if (v < neg_lim) begin
            saturate = neg_lim[SAT_WIDTH-1:0];
        end else begin
            saturate = v[SAT_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/ssb_phasing_tx_if.sv
// Audio-in / I-Q-out bundle of the SSB phasing modulator.
// Latency: n/a (wiring only).
// Backpressure: source holds audio_in/in_valid until in_ready; outputs are a pulse, no ready.
interface ssb_phasing_tx_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16
);
    logic signed [IN_WIDTH-1:0]  audio_in;
    logic                        in_valid;
    logic                        in_ready;
    logic                        lsb;
    logic signed [OUT_WIDTH-1:0] I_out;
    logic signed [OUT_WIDTH-1:0] Q_out;
    logic                        out_valid;

    modport master (
        output audio_in, in_valid, lsb,
        input  in_ready, I_out, Q_out, out_valid
    );

    modport slave (
        input  audio_in, in_valid, lsb,
        output in_ready, I_out, Q_out, out_valid
    );
endinterface

// File: rtl/hilbert_mac.sv
// Serial multiply-accumulate with a difference pre-adder: acc += k * (a - b).
// Latency: one term per cycle when en_i is high; clr_i zeroes the accumulator in one cycle.
// Backpressure: none, the controller sequences clr_i/en_i.
module hilbert_mac
    import hilbert_pkg::*;
#(
    parameter int IN_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_i,
    input  logic                          en_i,
    input  logic signed [IN_WIDTH-1:0]    a_i,
    input  logic signed [IN_WIDTH-1:0]    b_i,
    input  logic signed [COEFF_WIDTH-1:0] k_i,
    output logic signed [ACC_WIDTH-1:0]   acc_o
);
    localparam int PW = IN_WIDTH + 1 + COEFF_WIDTH;

    logic signed [IN_WIDTH:0]          diff;
    logic signed [PW-1:0]              prod;
    logic signed [ACC_WIDTH-1:0]       acc_q;
    logic signed [ACC_WIDTH-1:0]       acc_d;

    // Pre-adder exploits the odd symmetry so one multiply covers two taps
    always_comb begin
        diff  = {a_i[IN_WIDTH-1], a_i} - {b_i[IN_WIDTH-1], b_i};
        prod  = diff * k_i;
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + $signed({{(ACC_WIDTH - PW){prod[PW-1]}}, prod});
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/ssb_phasing_tx.sv
// SSB phasing modulator: I = audio delayed by 27 samples, Q = 55-tap Hilbert (negated for LSB).
// Latency: out_valid 15 cycles after accept; one sample per 16 cycles.
// Backpressure: in_ready low from accept until the result is registered; in_valid ignored then.
module ssb_phasing_tx
    import hilbert_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    ssb_phasing_tx_if.slave bus
);
    state_t                        state_q, state_d;
    logic [3:0]                    idx_q, idx_d;
    logic                          accept;
    logic                          mac_clr;
    logic                          mac_en;
    logic                          out_load;
    logic signed [IN_WIDTH-1:0]    h_q [N];
    logic                          lsb_q;
    logic [5:0]                    tap_lo;
    logic [5:0]                    tap_hi;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_shr;
    logic signed [SAT_WIDTH-1:0]   q_sat;
    logic signed [SAT_WIDTH-1:0]   q_fin;
    logic signed [OUT_WIDTH-1:0]   i_out_q;
    logic signed [OUT_WIDTH-1:0]   q_out_q;
    logic                          out_valid_q;

    // Next-state and control: accept in IDLE, 14 MAC terms, then one output cycle
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        accept   = 1'b0;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        out_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    mac_clr = 1'b1;
                    idx_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                idx_d  = idx_q + 4'd1;
                if (idx_q == 4'(NK - 1)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_load = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and term index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Sample history shifts only on accept; sideband choice latched with the sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                h_q[i] <= '0;
            end
            lsb_q <= 1'b0;
        end else if (accept) begin
            for (int i = N - 1; i > 0; i--) begin
                h_q[i] <= h_q[i-1];
            end
            h_q[0] <= bus.audio_in;
            lsb_q  <= bus.lsb;
        end
    end

    // Term j pairs h[2j] with its mirror h[54-2j]
    assign tap_lo = {1'b0, idx_q, 1'b0};
    assign tap_hi = 6'(N - 1) - tap_lo;

    hilbert_mac #(
        .IN_WIDTH (IN_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (h_q[tap_lo]),
        .b_i   (h_q[tap_hi]),
        .k_i   (HILBERT_K[idx_q]),
        .acc_o (acc)
    );

    // Rescale by the coefficient fraction bits, clamp, then pick the sideband
    always_comb begin
        acc_shr = acc >>> (COEFF_WIDTH - 1);
        q_sat   = saturate(acc_shr);
        q_fin   = lsb_q ? -q_sat : q_sat;
    end

    // Output registers hold between pulses; out_valid is a one-cycle strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_load;
            if (out_load) begin
                i_out_q <= OUT_WIDTH'(h_q[DELAY]);
                q_out_q <= OUT_WIDTH'(q_fin);
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.I_out     = i_out_q;
    assign bus.Q_out     = q_out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: doc/ssb_phasing_tx.md
# ssb_phasing_tx

Transmit-side SSB phasing modulator, the counterpart of the receive Hilbert path. It accepts real audio samples through a valid/ready handshake and emits an I/Q pair per sample: I is the audio delayed to the filter's group delay, Q is the 55-tap Hilbert transform. Q is negated to select the lower sideband. The block sits between the audio decimator/mic path and the TX upconverter/NCO mixer, and uses one shared multiplier with a serial MAC.

## Interface
Parameters:
- `IN_WIDTH`, 16: signed audio sample width.
- `OUT_WIDTH`, 16: signed I/Q output width.
- `COEFF_WIDTH`, 13: signed Hilbert coefficient width.
- `N`, 55: filter length; fixed odd, 14 non-zero coefficient magnitudes.
- `DELAY`, 27: I delay in samples, equal to (N-1)/2.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `audio_in`, in, IN_WIDTH: signed audio sample.
- `in_valid`, in, 1: `audio_in` is valid.
- `in_ready`, out, 1: block can accept a sample.
- `lsb`, in, 1: 0 = USB, 1 = LSB (negate Q); sampled at accept.
- `I_out`, out, OUT_WIDTH: signed delayed audio.
- `Q_out`, out, OUT_WIDTH: signed Hilbert output.
- `out_valid`, out, 1: one-cycle pulse, I/Q updated.

## Operation
- History `h[0..54]`, where `h[0]` is the newest sample. Accept occurs on a rising edge with `in_valid && in_ready`. On accept, all entries shift one place older, `audio_in` enters `h[0]`, and `lsb` is latched.
- Coefficients `k[0..13]` = 8, 10, 15, 23, 36, 55, 80, 114, 159, 223, 319, 482, 845, 2599.
- Q = sat(((Σ_{j=0..13} k[j]·(h[2j] − h[54−2j])) >>> 12)), using arithmetic shift by COEFF_WIDTH−1.
- If `lsb` was latched as 1, Q is negated after saturation. Because the saturated result is symmetric (see below), −(+32767) = −32767.
- I = `h[DELAY]` after the shift, i.e. the sample 27 accepts older than the newest.
- Widths:
  - difference: IN_WIDTH+1 = 17 bits
  - product: 30 bits
  - accumulator: 34 bits signed (no overflow possible)
  - saturation range: [−32767, +32767], symmetric
- FSM states:
  - IDLE: `in_ready` = 1; on accept go to MAC, with idx = 0 and acc = 0.
  - MAC: one term per cycle; idx runs 0..13. After idx = 13, go to OUT.
  - OUT: register `I_out`/`Q_out`, pulse `out_valid`, return to IDLE.
- `in_valid` is ignored outside IDLE. `audio_in` is not required to be held.
- The history is a register array; the shift occurs only on accept.

## Timing
- Accept on edge T. MAC terms are added on edges T+1..T+14. Outputs and `out_valid` are registered on edge T+15.
- `out_valid` is high for exactly the cycle following edge T+15.
- `in_ready` is low from after T until after T+15. Throughput is 1 sample per 16 cycles; a new accept is possible at T+16.
- `I_out`/`Q_out` hold their values between pulses.
- Reset values (`rst_n` low at an edge): `h[*]` = 0, acc = 0, idx = 0, FSM = IDLE, `I_out` = `Q_out` = 0, `out_valid` = 0, latched `lsb` = 0.
- `in_ready` reads 1 from the first edge after reset.
- Reset mid-MAC aborts the computation with no `out_valid` and clears the history.
- `in_valid` is ignored while `rst_n` is low.

## Structure
- Package `hilbert_pkg`: `COEFF_WIDTH`, `N`, `DELAY`, the 14-entry coefficient array `HILBERT_K`, and a saturate function shared with the RX Hilbert.
- One natural sub-module, `hilbert_mac`: a serial multiply-accumulate unit with difference pre-adder, clear, and enable inputs. FSM, history, and output registers stay in the top level.

## Test plan
- **Impulse, USB:** after reset, send 4096 then 54 zeros, with m = accept index 0..54.
  - Q = k[m/2] for even m ≤ 26 (m=0→8, m=26→2599).
  - Q = −k[(54−m)/2] for even m ≥ 28 (m=28→−2599, m=54→−8).
  - Q = 0 for odd m.
  - I = 4096 only at m = 27, otherwise 0.
- **Impulse, LSB:** same stimulus with `lsb` = 1 → all Q values negated (m=26→−2599); I unchanged.
- **Saturation:** send 28×(−32768) then 27×(+32767). The final Q = +32767 in USB and −32767 in LSB; I = −32768 on that sample.
- **Handshake:** hold `in_valid` = 1 continuously.
  - Accepts occur exactly every 16 cycles.
  - `out_valid` pulses 15 cycles after each accept.
  - Samples presented while `in_ready` = 0 are not consumed.
- **Reset mid-MAC:** assert `rst_n` = 0 at T+7 after an accept of 4096.
  - No `out_valid` pulse; outputs read 0.
  - 55 subsequent zero inputs give I = Q = 0 throughout.
- **DC:** 60 samples of 1000 → once the history is full, Q = 0 and I = 1000.
